param_lifo: RTL and testbench
=============================

PARAM_LIFO -- requirements
Module: param_lifo

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 32, data word width in bits, range 1..64.
- DEPTH, 16, number of entries, power of two, range 2..256.
- Derived: AW = clog2(DEPTH) for pointer width; CW = AW+1 for count width.
REQ-002 Ports SHALL be (name direction width meaning), clock and reset first:
- CLK in 1: clock; all state changes on rising edge.
- RST in 1: reset, asynchronous, active-high.
- FLUSH in 1: synchronous stack clear.
- CLR_ERR in 1: synchronous clear of sticky error flags.
- PUSH_STB in 1: push request.
- PUSH_DAT in DATA_W: push data.
- POP_STB in 1: pop request.
- POP_DAT out DATA_W: popped word, registered.
- PUSH_ACK out 1: one-cycle pulse confirming an accepted push.
- POP_ACK out 1: one-cycle pulse; POP_DAT valid in the same cycle.
- TOP_DAT out DATA_W: current top-of-stack word, combinational; 0 when empty.
- COUNT out CW: number of stored entries, 0..DEPTH.
- EMPTY out 1: COUNT==0.
- FULL out 1: COUNT==DEPTH.
- OVF out 1: sticky overflow flag.
- UNF out 1: sticky underflow flag.

Function
REQ-003 Storage SHALL be a DEPTH x DATA_W array addressed by COUNT; entry COUNT-1 is the top of stack.
REQ-004 An accepted push without a pop SHALL write PUSH_DAT to entry COUNT and increment COUNT by 1.
REQ-005 An accepted pop without a push SHALL latch entry COUNT-1 into POP_DAT and decrement COUNT by 1.
REQ-006 Push and pop in the same cycle with COUNT>=1 SHALL latch the old top into POP_DAT and overwrite the top with PUSH_DAT, leaving COUNT unchanged; this is legal when FULL=1. Both acks pulse.
REQ-007 Push and pop in the same cycle with COUNT==0 SHALL accept the push only, reject the pop, and set UNF.
REQ-008 A push alone while FULL=1 SHALL be rejected: no write, COUNT unchanged, no PUSH_ACK, OVF set.
REQ-009 A pop alone while EMPTY=1 SHALL be rejected: POP_DAT unchanged, no POP_ACK, UNF set.
REQ-010 PUSH_ACK and POP_ACK SHALL be registered and SHALL assert exactly one cycle after the accepting edge. They are asserted for one cycle per accepted operation, so back-to-back strobes give back-to-back acks.
REQ-011 Latency SHALL be: a pushed word appears on TOP_DAT after 1 edge; POP_DAT is valid 1 cycle after the POP_STB edge, coincident with POP_ACK.
REQ-012 COUNT SHALL never exceed DEPTH and never wrap below 0; EMPTY and FULL derive combinationally from COUNT.
REQ-013 FLUSH SHALL set COUNT to 0 and take priority over PUSH_STB and POP_STB in the same cycle. Strobes in that cycle are ignored, generate no acks and set no errors. Array contents are unchanged.
REQ-014 OVF and UNF SHALL stay set until CLR_ERR or RST. If CLR_ERR coincides with a new error event, the flag SHALL end the cycle set, because set wins.
REQ-015 POP_DAT SHALL hold its last value between pops.

Reset
REQ-016 While RST=1, the outputs SHALL be: COUNT=0, EMPTY=1, FULL=0, OVF=0, UNF=0, PUSH_ACK=0, POP_ACK=0, POP_DAT=0, TOP_DAT=0.
REQ-017 Array contents SHALL NOT require reset and SHALL never be observable while COUNT==0.
REQ-018 RST asserted mid-operation SHALL abort any pending ack. The first accepted operation after release SHALL behave as if on a freshly empty stack.

Verification
REQ-019 The bench SHALL cover the following directed scenarios (DATA_W=32, DEPTH=4):
- Push 0x11, 0x22, 0x33 on consecutive cycles, then 3 pops -> POP_DAT 0x33, 0x22, 0x11 with POP_ACK each cycle; COUNT ends 0, EMPTY=1.
- Push 4 words, then push 0x55 -> FULL=1, OVF=1, no PUSH_ACK, COUNT=4, TOP_DAT unchanged; then CLR_ERR -> OVF=0.
- Pop while empty -> UNF=1, no POP_ACK, POP_DAT unchanged. Push+pop while empty with 0xAA -> COUNT=1, TOP_DAT=0xAA, UNF=1.
- At COUNT=4 with top 0x44, push 0x99 and pop in the same cycle -> POP_DAT=0x44, TOP_DAT=0x99, COUNT=4, both acks pulse, OVF=0.
- At COUNT=2, assert FLUSH together with PUSH_STB -> COUNT=0, no ack, no error flags.
- At COUNT=3, assert RST async mid-cycle -> all outputs at reset values immediately. After release, push 0x01 -> COUNT=1, TOP_DAT=0x01.

Source files
------------

// File: rtl/param_lifo_if.sv
// Handshake bundle for param_lifo: control strobes and push data in,
// pop data, acks, occupancy and sticky error flags out.
interface param_lifo_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              FLUSH;
  logic              CLR_ERR;
  logic              PUSH_STB;
  logic [DATA_W-1:0] PUSH_DAT;
  logic              POP_STB;
  logic [DATA_W-1:0] POP_DAT;
  logic              PUSH_ACK;
  logic              POP_ACK;
  logic [DATA_W-1:0] TOP_DAT;
  logic [CW-1:0]     COUNT;
  logic              EMPTY;
  logic              FULL;
  logic              OVF;
  logic              UNF;

  modport master (
    output FLUSH, CLR_ERR, PUSH_STB, PUSH_DAT, POP_STB,
    input  POP_DAT, PUSH_ACK, POP_ACK, TOP_DAT, COUNT, EMPTY, FULL, OVF, UNF
  );

  modport slave (
    input  FLUSH, CLR_ERR, PUSH_STB, PUSH_DAT, POP_STB,
    output POP_DAT, PUSH_ACK, POP_ACK, TOP_DAT, COUNT, EMPTY, FULL, OVF, UNF
  );
endinterface

// File: rtl/param_lifo.sv
// Parameterized LIFO stack addressed by its occupancy count; registered pop
// data and acks, combinational top-of-stack view, sticky overflow/underflow.
module param_lifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input logic         CLK,
  input logic         RST,
  param_lifo_if.slave bus
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_pop_dat;
  logic              r_push_ack;
  logic              r_pop_ack;
  logic              r_ovf;
  logic              r_unf;

  logic          w_empty, w_full;
  logic          w_push_ok, w_pop_ok, w_swap;
  logic          w_ovf_evt, w_unf_evt;
  logic [AW-1:0] w_top_idx, w_wr_idx;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_top_idx = AW'(r_count - CW'(1));

  // A pop in the same cycle frees the top slot, so a push is only refused
  // when full and alone; FLUSH masks every strobe.
  assign w_push_ok = bus.PUSH_STB & ~bus.FLUSH & (~w_full | bus.POP_STB);
  assign w_pop_ok  = bus.POP_STB  & ~bus.FLUSH & ~w_empty;
  assign w_swap    = w_push_ok & w_pop_ok;
  assign w_ovf_evt = bus.PUSH_STB & ~bus.POP_STB & w_full & ~bus.FLUSH;
  assign w_unf_evt = bus.POP_STB & w_empty & ~bus.FLUSH;
  assign w_wr_idx  = w_swap ? w_top_idx : AW'(r_count);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count    <= '0;
      r_pop_dat  <= '0;
      r_push_ack <= 1'b0;
      r_pop_ack  <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_push_ack <= w_push_ok;
      r_pop_ack  <= w_pop_ok;
      if (bus.FLUSH)
        r_count <= '0;
      else if (w_push_ok && !w_pop_ok)
        r_count <= r_count + CW'(1);
      else if (w_pop_ok && !w_push_ok)
        r_count <= r_count - CW'(1);
      if (w_pop_ok)
        r_pop_dat <= r_mem[w_top_idx];
      // New error events override a coincident clear.
      if (w_ovf_evt)        r_ovf <= 1'b1;
      else if (bus.CLR_ERR) r_ovf <= 1'b0;
      if (w_unf_evt)        r_unf <= 1'b1;
      else if (bus.CLR_ERR) r_unf <= 1'b0;
    end
  end

  // Storage needs no reset: entries above COUNT are never observable.
  always_ff @(posedge CLK) begin
    if (w_push_ok && !RST)
      r_mem[w_wr_idx] <= bus.PUSH_DAT;
  end

  assign bus.POP_DAT  = r_pop_dat;
  assign bus.PUSH_ACK = r_push_ack;
  assign bus.POP_ACK  = r_pop_ack;
  assign bus.TOP_DAT  = w_empty ? '0 : r_mem[w_top_idx];
  assign bus.COUNT    = r_count;
  assign bus.EMPTY    = w_empty;
  assign bus.FULL     = w_full;
  assign bus.OVF      = r_ovf;
  assign bus.UNF      = r_unf;

endmodule

// File: tb/tb_param_lifo.sv
// Directed bench for param_lifo (DATA_W=32, DEPTH=4): ordering, full/empty
// rejection, swap, flush priority, sticky errors and async reset.
module tb_param_lifo;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  param_lifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  param_lifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.FLUSH = 0; bus.CLR_ERR = 0; bus.PUSH_STB = 0; bus.POP_STB = 0;
  endtask

  task automatic push(input logic [31:0] d);
    idle(); bus.PUSH_STB = 1; bus.PUSH_DAT = d; tick();
  endtask

  task automatic pop();
    idle(); bus.POP_STB = 1; tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, 64'(bus.COUNT), 0);
    chk({tag, "_empty"}, 64'(bus.EMPTY), 1);
    chk({tag, "_full"},  64'(bus.FULL), 0);
    chk({tag, "_ovf"},   64'(bus.OVF), 0);
    chk({tag, "_unf"},   64'(bus.UNF), 0);
    chk({tag, "_pack"},  64'(bus.PUSH_ACK), 0);
    chk({tag, "_oack"},  64'(bus.POP_ACK), 0);
    chk({tag, "_popd"},  64'(bus.POP_DAT), 0);
    chk({tag, "_top"},   64'(bus.TOP_DAT), 0);
  endtask

  initial begin
    idle(); bus.PUSH_DAT = '0;
    tick(); tick();
    chk_reset("rst");
    @(negedge CLK); RST = 0;

    // LIFO ordering
    push(32'h11); chk("p1_ack", 64'(bus.PUSH_ACK), 1); chk("p1_top", 64'(bus.TOP_DAT), 32'h11);
    push(32'h22); chk("p2_ack", 64'(bus.PUSH_ACK), 1);
    push(32'h33); chk("p3_cnt", 64'(bus.COUNT), 3); chk("p3_top", 64'(bus.TOP_DAT), 32'h33);
    pop(); chk("o1_dat", 64'(bus.POP_DAT), 32'h33); chk("o1_ack", 64'(bus.POP_ACK), 1);
    pop(); chk("o2_dat", 64'(bus.POP_DAT), 32'h22); chk("o2_ack", 64'(bus.POP_ACK), 1);
    pop(); chk("o3_dat", 64'(bus.POP_DAT), 32'h11); chk("o3_ack", 64'(bus.POP_ACK), 1);
    idle(); tick();
    chk("o_cnt", 64'(bus.COUNT), 0); chk("o_empty", 64'(bus.EMPTY), 1);
    chk("o_ackoff", 64'(bus.POP_ACK), 0); chk("o_hold", 64'(bus.POP_DAT), 32'h11);

    // Overflow
    push(32'h41); push(32'h42); push(32'h43); push(32'h44);
    chk("f_full", 64'(bus.FULL), 1); chk("f_cnt", 64'(bus.COUNT), 4);
    push(32'h55);
    chk("ovf_set", 64'(bus.OVF), 1); chk("ovf_noack", 64'(bus.PUSH_ACK), 0);
    chk("ovf_cnt", 64'(bus.COUNT), 4); chk("ovf_top", 64'(bus.TOP_DAT), 32'h44);
    idle(); bus.CLR_ERR = 1; tick();
    chk("ovf_clr", 64'(bus.OVF), 0);

    // Swap while full
    idle(); bus.PUSH_STB = 1; bus.POP_STB = 1; bus.PUSH_DAT = 32'h99; tick();
    chk("sw_popd", 64'(bus.POP_DAT), 32'h44); chk("sw_top", 64'(bus.TOP_DAT), 32'h99);
    chk("sw_cnt", 64'(bus.COUNT), 4); chk("sw_pack", 64'(bus.PUSH_ACK), 1);
    chk("sw_oack", 64'(bus.POP_ACK), 1); chk("sw_ovf", 64'(bus.OVF), 0);
    pop(); chk("sw_below", 64'(bus.POP_DAT), 32'h99);
    chk("sw_top2", 64'(bus.TOP_DAT), 32'h43);

    // Underflow
    idle(); bus.FLUSH = 1; tick();
    chk("fl_cnt", 64'(bus.COUNT), 0); chk("fl_top", 64'(bus.TOP_DAT), 0);
    pop();
    chk("unf_set", 64'(bus.UNF), 1); chk("unf_noack", 64'(bus.POP_ACK), 0);
    chk("unf_hold", 64'(bus.POP_DAT), 32'h99);
    idle(); bus.PUSH_STB = 1; bus.POP_STB = 1; bus.PUSH_DAT = 32'hAA; tick();
    chk("pe_cnt", 64'(bus.COUNT), 1); chk("pe_top", 64'(bus.TOP_DAT), 32'hAA);
    chk("pe_unf", 64'(bus.UNF), 1); chk("pe_pack", 64'(bus.PUSH_ACK), 1);
    chk("pe_oack", 64'(bus.POP_ACK), 0);
    idle(); bus.CLR_ERR = 1; tick();
    chk("unf_clr", 64'(bus.UNF), 0);

    // Flush beats push
    push(32'hBB); chk("fp_cnt2", 64'(bus.COUNT), 2);
    idle(); bus.FLUSH = 1; bus.PUSH_STB = 1; bus.PUSH_DAT = 32'hCC; tick();
    chk("fp_cnt", 64'(bus.COUNT), 0); chk("fp_pack", 64'(bus.PUSH_ACK), 0);
    chk("fp_ovf", 64'(bus.OVF), 0); chk("fp_unf", 64'(bus.UNF), 0);

    // Error set wins over a coincident clear
    idle(); bus.CLR_ERR = 1; bus.POP_STB = 1; tick();
    chk("setwin", 64'(bus.UNF), 1);
    idle(); bus.CLR_ERR = 1; tick();
    chk("setwin_clr", 64'(bus.UNF), 0);

    // Async reset with an ack still showing
    push(32'h61); push(32'h62); push(32'h63);
    chk("r_cnt3", 64'(bus.COUNT), 3); chk("r_ack", 64'(bus.PUSH_ACK), 1);
    idle();
    #2 RST = 1;
    #1 chk_reset("arst");
    @(negedge CLK); RST = 0;
    tick(); chk("rel_ack", 64'(bus.PUSH_ACK), 0);
    push(32'h01);
    chk("rel_cnt", 64'(bus.COUNT), 1); chk("rel_top", 64'(bus.TOP_DAT), 32'h01);
    pop(); chk("rel_pop", 64'(bus.POP_DAT), 32'h01); chk("rel_empty", 64'(bus.EMPTY), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
